// File: rtl/reg_file_sb_pkg.sv
// Shared definitions for the register file / scoreboard slice: default
// geometry and the register indices that decode refers to by name.
package reg_file_sb_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_N_REGS  = 8;
  localparam bit DEF_R0_ZERO = 1'b0;

  // Index of the register that may be hardwired to zero.
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/reg_sb_bits.sv
// Per-register busy scoreboard. An accepted issue marks its destination
// pending; a write-back to that destination clears it. A write-back that finds
// its destination not pending raises a sticky error flag.
//
// Issue handshake (valid/ready): issue_en is the request and issue_ready is the
// grant. A transfer happens only in a cycle where both are high. When
// issue_ready is low, nothing changes and the requester keeps issue_en and
// issue_addr asserted until it is granted. issue_ready may depend
// combinationally on issue_en, issue_addr and the write-back inputs of the
// same cycle.
module reg_sb_bits
  import reg_file_sb_pkg::*;
#(
  parameter int N_REGS  = DEF_N_REGS,
  parameter int ADDR_W  = $clog2(N_REGS),
  parameter bit R0_ZERO = DEF_R0_ZERO
) (
  input  logic              clk,
  input  logic              rst_n,
  // Already qualified by the caller: in range and not the hardwired zero register.
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              issue_ready,
  output logic [N_REGS-1:0] busy_vec,
  output logic              wb_err
);

  logic [N_REGS-1:0] busy_q;
  logic [N_REGS-1:0] busy_d;
  logic              wb_err_q;
  logic              issue_hit;
  logic              issue_busy;
  logic              wr_busy;
  logic              wr_same;
  logic              issue_ok;

  // Look up the pending bits of the issue and write-back destinations.
  // An index outside the file reports no hit.
  always_comb begin
    issue_hit  = 1'b0;
    issue_busy = 1'b0;
    wr_busy    = 1'b0;
    for (int i = 0; i < N_REGS; i++) begin
      if (issue_addr == ADDR_W'(i)) begin
        issue_hit  = 1'b1;
        issue_busy = busy_q[i];
      end
      if (wr_addr == ADDR_W'(i)) begin
        wr_busy = busy_q[i];
      end
    end
    // A result landing in this cycle frees the destination for a new issue.
    wr_same  = wr_en && (wr_addr == issue_addr);
    issue_ok = issue_en && issue_hit && !(issue_busy && !wr_same);
  end

  // Next busy bits: an accepted issue wins over a same-cycle clear.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < N_REGS; i++) begin
      if (issue_ok && (issue_addr == ADDR_W'(i)) && !(R0_ZERO && (i == REG_ZERO))) begin
        busy_d[i] = 1'b1;
      end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
        busy_d[i] = 1'b0;
      end
    end
  end

  // Scoreboard state and the sticky write-back error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= '0;
      wb_err_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (wr_en && !wr_busy) begin
        wb_err_q <= 1'b1;
      end
    end
  end

  assign issue_ready = issue_ok;
  assign busy_vec    = busy_q;
  assign wb_err      = wb_err_q;

endmodule

// File: rtl/reg_file_sb.sv
// General register file with one write-back port, two bypassed read ports and
// a per-register busy scoreboard. Also exports a flat image of all registers.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int N_REGS  = DEF_N_REGS,
  parameter int ADDR_W  = $clog2(N_REGS),
  parameter bit R0_ZERO = DEF_R0_ZERO
) (
  input  logic                     CLK_WB,
  input  logic                     RESET_N,
  input  logic                     WR_EN,
  input  logic [ADDR_W-1:0]        WR_ADDR,
  input  logic [DATA_W-1:0]        WR_DATA,
  input  logic                     ISSUE_EN,
  input  logic [ADDR_W-1:0]        ISSUE_ADDR,
  output logic                     ISSUE_READY,
  input  logic [ADDR_W-1:0]        RD_ADDR_A,
  output logic [DATA_W-1:0]        RD_DATA_A,
  output logic                     RD_BUSY_A,
  input  logic [ADDR_W-1:0]        RD_ADDR_B,
  output logic [DATA_W-1:0]        RD_DATA_B,
  output logic                     RD_BUSY_B,
  output logic [N_REGS-1:0]        BUSY_VEC,
  output logic                     WB_ERR,
  output logic [N_REGS*DATA_W-1:0] REG_FLAT
);

  logic [DATA_W-1:0] regs_q [N_REGS];
  logic              wr_hit;
  logic              wr_ok;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic              busy_a;
  logic              busy_b;

  // A write counts only when it targets a real register that is not hardwired to zero.
  always_comb begin
    wr_hit = 1'b0;
    for (int i = 0; i < N_REGS; i++) begin
      if (WR_ADDR == ADDR_W'(i)) begin
        wr_hit = 1'b1;
      end
    end
    wr_ok = WR_EN && wr_hit && !(R0_ZERO && (WR_ADDR == ADDR_W'(REG_ZERO)));
  end

  reg_sb_bits #(
    .N_REGS  (N_REGS),
    .ADDR_W  (ADDR_W),
    .R0_ZERO (R0_ZERO)
  ) u_sb (
    .clk         (CLK_WB),
    .rst_n       (RESET_N),
    .wr_en       (wr_ok),
    .wr_addr     (WR_ADDR),
    .issue_en    (ISSUE_EN),
    .issue_addr  (ISSUE_ADDR),
    .issue_ready (ISSUE_READY),
    .busy_vec    (BUSY_VEC),
    .wb_err      (WB_ERR)
  );

  // Register storage; a write lands at the rising edge and is visible next cycle.
  always_ff @(posedge CLK_WB or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < N_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_ok) begin
      for (int i = 0; i < N_REGS; i++) begin
        if (WR_ADDR == ADDR_W'(i)) begin
          regs_q[i] <= WR_DATA;
        end
      end
    end
  end

  // Read muxes with same-cycle write-back bypass. An index outside the file
  // reads zero and not pending; a result arriving this cycle reads as ready.
  always_comb begin
    data_a = '0;
    data_b = '0;
    busy_a = 1'b0;
    busy_b = 1'b0;
    for (int i = 0; i < N_REGS; i++) begin
      if (RD_ADDR_A == ADDR_W'(i)) begin
        data_a = regs_q[i];
        busy_a = BUSY_VEC[i];
      end
      if (RD_ADDR_B == ADDR_W'(i)) begin
        data_b = regs_q[i];
        busy_b = BUSY_VEC[i];
      end
    end
    if (wr_ok && (WR_ADDR == RD_ADDR_A)) begin
      data_a = WR_DATA;
      busy_a = 1'b0;
    end
    if (wr_ok && (WR_ADDR == RD_ADDR_B)) begin
      data_b = WR_DATA;
      busy_b = 1'b0;
    end
    if (R0_ZERO && (RD_ADDR_A == ADDR_W'(REG_ZERO))) begin
      data_a = '0;
      busy_a = 1'b0;
    end
    if (R0_ZERO && (RD_ADDR_B == ADDR_W'(REG_ZERO))) begin
      data_b = '0;
      busy_b = 1'b0;
    end
  end

  assign RD_DATA_A = data_a;
  assign RD_DATA_B = data_b;
  assign RD_BUSY_A = busy_a;
  assign RD_BUSY_B = busy_b;

  // Flat debug image: register i at [i*DATA_W +: DATA_W].
  for (genvar g = 0; g < N_REGS; g++) begin : g_flat
    assign REG_FLAT[g*DATA_W +: DATA_W] = regs_q[g];
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a default instance (R0 writable) plus two
// hardwired-zero instances, 16x8 and 32x16.
module tb_reg_file_sb;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  // ---------------- default instance: 16 bit x 8, R0 writable ----------------
  logic         wr_en, issue_en, issue_ready, rd_busy_a, rd_busy_b, wb_err;
  logic [2:0]   wr_addr, issue_addr, rd_addr_a, rd_addr_b;
  logic [15:0]  wr_data, rd_data_a, rd_data_b;
  logic [7:0]   busy_vec;
  logic [127:0] reg_flat;

  reg_file_sb dut (
    .CLK_WB(clk), .RESET_N(rst_n),
    .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .ISSUE_EN(issue_en), .ISSUE_ADDR(issue_addr), .ISSUE_READY(issue_ready),
    .RD_ADDR_A(rd_addr_a), .RD_DATA_A(rd_data_a), .RD_BUSY_A(rd_busy_a),
    .RD_ADDR_B(rd_addr_b), .RD_DATA_B(rd_data_b), .RD_BUSY_B(rd_busy_b),
    .BUSY_VEC(busy_vec), .WB_ERR(wb_err), .REG_FLAT(reg_flat)
  );

  // ---------------- hardwired-zero instance: 16 bit x 8 ----------------
  logic         c_wr_en, c_issue_en, c_issue_ready, c_rd_busy_a, c_rd_busy_b, c_wb_err;
  logic [2:0]   c_wr_addr, c_issue_addr, c_rd_addr_a, c_rd_addr_b;
  logic [15:0]  c_wr_data, c_rd_data_a, c_rd_data_b;
  logic [7:0]   c_busy_vec;
  logic [127:0] c_reg_flat;

  reg_file_sb #(.DATA_W(16), .N_REGS(8), .R0_ZERO(1'b1)) dut_c (
    .CLK_WB(clk), .RESET_N(rst_n),
    .WR_EN(c_wr_en), .WR_ADDR(c_wr_addr), .WR_DATA(c_wr_data),
    .ISSUE_EN(c_issue_en), .ISSUE_ADDR(c_issue_addr), .ISSUE_READY(c_issue_ready),
    .RD_ADDR_A(c_rd_addr_a), .RD_DATA_A(c_rd_data_a), .RD_BUSY_A(c_rd_busy_a),
    .RD_ADDR_B(c_rd_addr_b), .RD_DATA_B(c_rd_data_b), .RD_BUSY_B(c_rd_busy_b),
    .BUSY_VEC(c_busy_vec), .WB_ERR(c_wb_err), .REG_FLAT(c_reg_flat)
  );

  // ---------------- hardwired-zero instance: 32 bit x 16 ----------------
  logic         w_wr_en, w_issue_en, w_issue_ready, w_rd_busy_a, w_rd_busy_b, w_wb_err;
  logic [3:0]   w_wr_addr, w_issue_addr, w_rd_addr_a, w_rd_addr_b;
  logic [31:0]  w_wr_data, w_rd_data_a, w_rd_data_b;
  logic [15:0]  w_busy_vec;
  logic [511:0] w_reg_flat;

  reg_file_sb #(.DATA_W(32), .N_REGS(16), .R0_ZERO(1'b1)) dut_w (
    .CLK_WB(clk), .RESET_N(rst_n),
    .WR_EN(w_wr_en), .WR_ADDR(w_wr_addr), .WR_DATA(w_wr_data),
    .ISSUE_EN(w_issue_en), .ISSUE_ADDR(w_issue_addr), .ISSUE_READY(w_issue_ready),
    .RD_ADDR_A(w_rd_addr_a), .RD_DATA_A(w_rd_data_a), .RD_BUSY_A(w_rd_busy_a),
    .RD_ADDR_B(w_rd_addr_b), .RD_DATA_B(w_rd_data_b), .RD_BUSY_B(w_rd_busy_b),
    .BUSY_VEC(w_busy_vec), .WB_ERR(w_wb_err), .REG_FLAT(w_reg_flat)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_all();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; issue_en = 1'b0; issue_addr = '0;
    c_wr_en = 1'b0; c_wr_addr = '0; c_wr_data = '0; c_issue_en = 1'b0; c_issue_addr = '0;
    w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0; w_issue_en = 1'b0; w_issue_addr = '0;
  endtask

  // Advance past the next rising edge so registered outputs have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [127:0] c_exp;
  logic [511:0] w_exp;
  logic [31:0]  w_val;
  logic [15:0]  c_val;

  initial begin
    rst_n = 1'b0;
    idle_all();
    rd_addr_a = '0; rd_addr_b = '0;
    c_rd_addr_a = '0; c_rd_addr_b = '0;
    w_rd_addr_a = '0; w_rd_addr_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_busy", busy_vec, 0);
    check("rst_wb_err", wb_err, 0);
    check("rst_flat", reg_flat, 0);
    check("rst_w_flat", w_reg_flat, 0);

    // Issue r2, then write back 16'hBEEF.
    exp_q.push_back(16'h0004);
    exp_q.push_back(16'h0004);
    exp_q.push_back(16'h0000);
    @(negedge clk);
    issue_en = 1'b1; issue_addr = 3'd2; rd_addr_a = 3'd2;
    #1;
    check("iss2_ready", issue_ready, 1);
    check("iss2_rdbusy_pre", rd_busy_a, 0);
    tick();
    check("iss2_busy", busy_vec, exp_q.pop_front());
    @(negedge clk);
    issue_en = 1'b0;
    #1;
    check("r2_rdbusy_pending", rd_busy_a, 1);
    tick();
    check("r2_busy_hold", busy_vec, exp_q.pop_front());
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hBEEF;
    #1;
    check("r2_bypass_data", rd_data_a, 16'hBEEF);
    check("r2_bypass_busy", rd_busy_a, 0);
    check("r2_store_pre", reg_flat[2*16 +: 16], 16'h0000);
    tick();
    check("r2_busy_clear", busy_vec, exp_q.pop_front());
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    check("r2_stored_rd", rd_data_a, 16'hBEEF);
    check("r2_stored_flat", reg_flat[2*16 +: 16], 16'hBEEF);
    check("r2_no_err", wb_err, 0);

    // Issue to a busy r4: stalled without write-back, granted with one.
    @(negedge clk);
    issue_en = 1'b1; issue_addr = 3'd4;
    #1;
    check("iss4_ready", issue_ready, 1);
    tick();
    check("iss4_busy", busy_vec, 8'h10);
    @(negedge clk);
    #1;
    check("iss4_stall", issue_ready, 0);
    tick();
    check("iss4_stall_busy", busy_vec, 8'h10);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h4444;
    #1;
    check("iss4_wb_ready", issue_ready, 1);
    tick();
    check("iss4_wb_busy", busy_vec, 8'h10);
    check("iss4_wb_err", wb_err, 0);
    check("iss4_wb_flat", reg_flat[4*16 +: 16], 16'h4444);
    @(negedge clk);
    issue_en = 1'b0; wr_data = 16'h4445;
    tick();
    check("r4_busy_clear", busy_vec, 8'h00);
    check("r4_flat", reg_flat[4*16 +: 16], 16'h4445);

    // Both read ports on r1 during its write-back.
    @(negedge clk);
    wr_en = 1'b0; issue_en = 1'b1; issue_addr = 3'd1;
    tick();
    check("iss1_busy", busy_vec, 8'h02);
    @(negedge clk);
    issue_en = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'hA5A5;
    rd_addr_a = 3'd1; rd_addr_b = 3'd1;
    #1;
    check("r1_byp_a", rd_data_a, 16'hA5A5);
    check("r1_byp_b", rd_data_b, 16'hA5A5);
    check("r1_byp_busy_a", rd_busy_a, 0);
    check("r1_byp_busy_b", rd_busy_b, 0);
    check("r1_store_pre", reg_flat[1*16 +: 16], 16'h0000);
    tick();
    check("r1_flat", reg_flat[1*16 +: 16], 16'hA5A5);
    check("r1_busy_clear", busy_vec, 8'h00);
    @(negedge clk);
    wr_en = 1'b0; rd_addr_b = 3'd2;
    #1;
    check("r1_port_a", rd_data_a, 16'hA5A5);
    check("r2_port_b", rd_data_b, 16'hBEEF);
    check("pre_err_clear", wb_err, 0);

    // Write-back to a non-busy r6 raises the sticky error.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h0001;
    tick();
    check("r6_err_set", wb_err, 1);
    check("r6_flat", reg_flat[6*16 +: 16], 16'h0001);
    @(negedge clk);
    wr_en = 1'b0;
    repeat (3) tick();
    check("r6_err_sticky", wb_err, 1);

    // Asynchronous reset in the middle of a cycle with traffic in flight.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234;
    issue_en = 1'b1; issue_addr = 3'd5;
    tick();
    check("pre_rst_busy", busy_vec, 8'h20);
    check("pre_rst_r3", reg_flat[3*16 +: 16], 16'h1234);
    @(negedge clk);
    wr_addr = 3'd7; wr_data = 16'h7777; issue_addr = 3'd0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_flat", reg_flat, 0);
    check("arst_busy", busy_vec, 0);
    check("arst_err", wb_err, 0);
    tick();
    check("arst_hold_flat", reg_flat, 0);
    check("arst_hold_busy", busy_vec, 0);
    @(negedge clk);
    idle_all();
    rst_n = 1'b1;

    // Hardwired zero register: write and issue to r0 together.
    @(negedge clk);
    c_wr_en = 1'b1; c_wr_addr = 3'd0; c_wr_data = 16'hFFFF;
    c_issue_en = 1'b1; c_issue_addr = 3'd0; c_rd_addr_a = 3'd0;
    w_wr_en = 1'b1; w_wr_addr = 4'd0; w_wr_data = 32'hFFFF_FFFF;
    w_issue_en = 1'b1; w_issue_addr = 4'd0; w_rd_addr_a = 4'd0;
    #1;
    check("c_r0_ready", c_issue_ready, 1);
    check("c_r0_nobyp", c_rd_data_a, 16'h0000);
    check("w_r0_ready", w_issue_ready, 1);
    check("w_r0_nobyp", w_rd_data_a, 32'h0);
    tick();
    check("c_r0_busy", c_busy_vec, 0);
    check("c_r0_err", c_wb_err, 0);
    check("c_r0_flat", c_reg_flat, 0);
    check("w_r0_busy", w_busy_vec, 0);
    check("w_r0_err", w_wb_err, 0);
    check("w_r0_flat", w_reg_flat, 0);
    check("c_r0_rd", c_rd_data_a, 16'h0000);

    // Fill every other register (issue, then write back) and compare REG_FLAT.
    c_exp = '0;
    w_exp = '0;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      c_wr_en = 1'b0; w_wr_en = 1'b0;
      w_issue_en = 1'b1; w_issue_addr = 4'(i);
      c_issue_en = (i < 8); c_issue_addr = 3'(i);
      tick();
      @(negedge clk);
      w_issue_en = 1'b0; c_issue_en = 1'b0;
      w_val = {16'hC0DE, 16'(i * 257)};
      w_wr_en = 1'b1; w_wr_addr = 4'(i); w_wr_data = w_val;
      w_exp[i*32 +: 32] = w_val;
      c_val = 16'(i * 16'h1111);
      c_wr_en = (i < 8); c_wr_addr = 3'(i); c_wr_data = c_val;
      if (i < 8) c_exp[i*16 +: 16] = c_val;
      tick();
    end
    @(negedge clk);
    idle_all();
    w_rd_addr_a = 4'd15; c_rd_addr_b = 3'd7;
    #1;
    check("w_fill_flat", w_reg_flat, w_exp);
    check("w_fill_busy", w_busy_vec, 0);
    check("w_fill_err", w_wb_err, 0);
    check("w_fill_r15", w_rd_data_a, 32'hC0DE_0F0F);
    check("c_fill_flat", c_reg_flat, c_exp);
    check("c_fill_busy", c_busy_vec, 0);
    check("c_fill_err", c_wb_err, 0);
    check("c_fill_r7", c_rd_data_b, 16'h7777);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
